range_peak_detector: RTL and testbench
======================================

RANGE_PEAK_DETECTOR -- requirements
Module: range_peak_detector

Interface
REQ-001 SHALL have parameter FRAME_LENGTH, default 128: FFT bins per frame, power of two, 8..1024.
REQ-002 SHALL have parameter DATA_W, default 16: signed width of each real/imag component.
REQ-003 SHALL have parameter SKIP_BINS, default 1: leading bins (DC leakage) excluded from peak search.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port s_tvalid, input, 1: FFT output beat valid.
REQ-007 Port s_tready, output, 1: block accepts the beat.
REQ-008 Port s_tdata, input, 2*DATA_W: [DATA_W-1:0] real, [2*DATA_W-1:DATA_W] imag, two's complement.
REQ-009 Port s_tlast, input, 1: last bin of frame.
REQ-010 Port threshold, input, 2*DATA_W+1: detection threshold on squared magnitude, unsigned.
REQ-011 Port m_valid, output, 1: frame result valid.
REQ-012 Port m_ready, input, 1: consumer takes the result.
REQ-013 Port m_bin, output, $clog2(FRAME_LENGTH): index of peak bin.
REQ-014 Port m_mag, output, 2*DATA_W+1: squared magnitude of peak bin.
REQ-015 Port m_detect, output, 1: m_mag strictly greater than threshold.
REQ-016 Port m_frame_err, output, 1: tlast position disagreed with FRAME_LENGTH.

Function
REQ-017 A beat SHALL transfer only on a cycle where s_tvalid and s_tready are both 1.
REQ-018 Squared magnitude SHALL be re*re + im*im, full precision, 2*DATA_W+1 bits unsigned, no truncation or saturation.
REQ-019 Magnitude SHALL be computed in a 2-stage pipeline (stage 1: products registered; stage 2: sum registered) carrying bin index and end-of-frame tag.
REQ-020 A bin counter SHALL start at 0 per frame, increment per accepted beat, and tag each beat with its index.
REQ-021 Frame end SHALL be the beat with s_tlast=1 or bin index FRAME_LENGTH-1, whichever comes first.
REQ-022 m_frame_err SHALL be 1 if tlast arrives at index < FRAME_LENGTH-1, or if index FRAME_LENGTH-1 arrives without tlast; beats after a forced end start a new frame at index 0.
REQ-023 Peak search SHALL ignore bins with index < SKIP_BINS; the first eligible bin initialises the running max.
REQ-024 A bin SHALL replace the running max only if strictly greater; ties keep the lowest index.
REQ-025 If a frame ends with no eligible bin, the result SHALL be m_bin=0, m_mag=0, m_detect=0.
REQ-026 threshold SHALL be sampled when the result is latched; m_detect SHALL be evaluated at that moment.
REQ-027 FSM states: ACCUM (s_tready=1), FLUSH (s_tready=0, 2 cycles, pipeline drains), HOLD (s_tready=0, m_valid=1).
REQ-028 ACCUM->FLUSH on acceptance of the frame-end beat; FLUSH->HOLD after the tagged beat leaves stage 2, latching m_bin/m_mag/m_detect/m_frame_err.
REQ-029 HOLD->ACCUM on m_valid && m_ready; running max and error flag SHALL clear on this transition.
REQ-030 Latency: frame-end beat accepted in cycle N -> m_valid=1 from cycle N+3; s_tready=1 again the cycle after the m_ready handshake.
REQ-031 Result outputs SHALL remain stable while m_valid=1 and m_ready=0.

Reset
REQ-032 On rst: state ACCUM, s_tready=1, m_valid=0, m_bin=0, m_mag=0, m_detect=0, m_frame_err=0, counter=0, pipeline valids=0.
REQ-033 Reset mid-frame or mid-HOLD SHALL discard the partial frame and pending result; no m_valid until a complete new frame.

Structure
REQ-034 Shared radar package SHALL hold FRAME_LENGTH default, DATA_W default, the derived bin-index and magnitude widths, and the FSM state encoding.
REQ-035 Squaring/sum pipeline SHALL be a sub-module named cmag_sq_pipe; FSM, counter and peak tracking SHALL stay in the top.

Verification
REQ-036 128 beats, bin 37 = (300,-400), others (1,1), tlast on 127 -> m_bin=37, m_mag=250000, m_frame_err=0, m_valid at cycle N+3.
REQ-037 Bin 0=(10000,0), bin 5=(100,0), rest 0, SKIP_BINS=1 -> m_bin=5, m_mag=10000.
REQ-038 Bins 20 and 90 both (-32768,-32768) -> m_bin=20, m_mag=2147483648 (full 33-bit value).
REQ-039 tlast on index 63 -> result at N+3 with m_frame_err=1; next frame with no tlast at 127 -> forced end, m_frame_err=1.
REQ-040 m_ready held 0 for 20 cycles -> s_tready=0, outputs stable throughout; threshold=250000 with peak 250000 -> m_detect=0, threshold=249999 -> m_detect=1.
REQ-041 rst pulsed at beat 60 -> no m_valid; next clean frame produces a correct result.

Source files
------------

// File: rtl/range_peak_detector_pkg.sv
// -----------------------------------------------------------------------------
// range_peak_detector_pkg
// Shared radar definitions: default frame length and sample width, derived
// bin-index and squared-magnitude widths, and the detector FSM encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package range_peak_detector_pkg;

   localparam int unsigned DEF_FRAME_LENGTH = 128;
   localparam int unsigned DEF_DATA_W       = 16;

   function automatic int unsigned bin_width(input int unsigned frame_length);
      return $clog2(frame_length);
   endfunction

   // re^2 + im^2 of two's complement DATA_W values needs 2*DATA_W+1 bits
   function automatic int unsigned mag_width(input int unsigned data_w);
      return 2 * data_w + 1;
   endfunction

   localparam int unsigned DEF_BIN_W = bin_width(DEF_FRAME_LENGTH);
   localparam int unsigned DEF_MAG_W = mag_width(DEF_DATA_W);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/cmag_sq_pipe.sv
// -----------------------------------------------------------------------------
// cmag_sq_pipe
// Two-stage squared-magnitude pipeline: stage 1 registers re*re and im*im,
// stage 2 registers their full-precision sum. Bin index and end-of-frame tag
// travel alongside the data.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid            input beat valid
//   in_re, in_im        signed components
//   in_bin, in_last     bin index and frame-end tag of the beat
//   out_valid           stage-2 result valid
//   out_mag             re^2 + im^2, unsigned, 2*DATA_W+1 bits
//   out_bin, out_last   tags aligned with out_mag
// -----------------------------------------------------------------------------
module cmag_sq_pipe
   import range_peak_detector_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned BIN_W  = DEF_BIN_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   input  logic [BIN_W-1:0]         in_bin,
   input  logic                     in_last,
   output logic                     out_valid,
   output logic [2*DATA_W:0]        out_mag,
   output logic [BIN_W-1:0]         out_bin,
   output logic                     out_last
);

   logic signed [2*DATA_W-1:0] re_x;
   logic signed [2*DATA_W-1:0] im_x;
   logic signed [2*DATA_W-1:0] sq_re;
   logic signed [2*DATA_W-1:0] sq_im;

   logic                       v1;
   logic [2*DATA_W-1:0]        prod_re;
   logic [2*DATA_W-1:0]        prod_im;
   logic [BIN_W-1:0]           bin1;
   logic                       last1;

   // Operands widened first so the products are computed at full width.
   // A square is never negative and at most 2^(2*DATA_W-2), so reinterpreting
   // it as unsigned is lossless.
   assign re_x  = (2*DATA_W)'(in_re);
   assign im_x  = (2*DATA_W)'(in_im);
   assign sq_re = re_x * re_x;
   assign sq_im = im_x * im_x;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         prod_re   <= '0;
         prod_im   <= '0;
         bin1      <= '0;
         last1     <= 1'b0;
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_bin   <= '0;
         out_last  <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            prod_re <= sq_re;
            prod_im <= sq_im;
            bin1    <= in_bin;
            last1   <= in_last;
         end
         out_valid <= v1;
         if (v1) begin
            out_mag  <= {1'b0, prod_re} + {1'b0, prod_im};
            out_bin  <= bin1;
            out_last <= last1;
         end
      end
   end

endmodule

// File: rtl/range_peak_detector.sv
// -----------------------------------------------------------------------------
// range_peak_detector
// Finds the strongest bin of each FFT frame by squared magnitude, ignoring
// the first SKIP_BINS bins, and reports it with a threshold detection flag
// and a frame-length error flag. One result is held until consumed; input
// is stalled from frame end until the result handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_tvalid/s_tready   input beat handshake
//   s_tdata             {imag, real}, two's complement DATA_W each
//   s_tlast             last bin of frame
//   threshold           detection threshold on squared magnitude
//   m_valid/m_ready     result handshake
//   m_bin, m_mag        peak bin index and its squared magnitude
//   m_detect            m_mag > threshold (sampled at result latch)
//   m_frame_err         tlast position disagreed with FRAME_LENGTH
// -----------------------------------------------------------------------------
module range_peak_detector
   import range_peak_detector_pkg::*;
#(
   parameter int unsigned FRAME_LENGTH = DEF_FRAME_LENGTH,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned SKIP_BINS    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                s_tvalid,
   output logic                                s_tready,
   input  logic [2*DATA_W-1:0]                 s_tdata,
   input  logic                                s_tlast,
   input  logic [mag_width(DATA_W)-1:0]        threshold,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [bin_width(FRAME_LENGTH)-1:0]  m_bin,
   output logic [mag_width(DATA_W)-1:0]        m_mag,
   output logic                                m_detect,
   output logic                                m_frame_err
);

   localparam int unsigned BIN_W = bin_width(FRAME_LENGTH);
   localparam int unsigned MAG_W = mag_width(DATA_W);
   localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FRAME_LENGTH - 1);

   state_t             state;
   logic [BIN_W-1:0]   bin_cnt;
   logic               accept;
   logic               at_last_idx;
   logic               frame_end;
   logic               err_now;
   logic               err_q;

   logic               p_valid;
   logic [MAG_W-1:0]   p_mag;
   logic [BIN_W-1:0]   p_bin;
   logic               p_last;

   logic [MAG_W-1:0]   max_mag;
   logic [BIN_W-1:0]   max_bin;
   logic               have_max;
   logic               eligible;
   logic               take;
   logic [MAG_W-1:0]   nxt_mag;
   logic [BIN_W-1:0]   nxt_bin;

   assign accept      = s_tvalid & s_tready;
   assign at_last_idx = (bin_cnt == LAST_IDX);
   assign frame_end   = s_tlast | at_last_idx;
   // Early tlast or a full frame without tlast: exactly one of the two is set
   assign err_now     = s_tlast ^ at_last_idx;

   cmag_sq_pipe #(
      .DATA_W (DATA_W),
      .BIN_W  (BIN_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_re     (s_tdata[DATA_W-1:0]),
      .in_im     (s_tdata[2*DATA_W-1:DATA_W]),
      .in_bin    (bin_cnt),
      .in_last   (frame_end),
      .out_valid (p_valid),
      .out_mag   (p_mag),
      .out_bin   (p_bin),
      .out_last  (p_last)
   );

   // Running max including the beat leaving the pipe this cycle, so the
   // frame-end beat is part of the latched result.
   always_comb begin
      eligible = p_valid && (32'(p_bin) >= SKIP_BINS);
      take     = eligible && (!have_max || (p_mag > max_mag));
      nxt_mag  = max_mag;
      nxt_bin  = max_bin;
      if (take) begin
         nxt_mag = p_mag;
         nxt_bin = p_bin;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_ACCUM;
         s_tready    <= 1'b1;
         m_valid     <= 1'b0;
         m_bin       <= '0;
         m_mag       <= '0;
         m_detect    <= 1'b0;
         m_frame_err <= 1'b0;
         bin_cnt     <= '0;
         err_q       <= 1'b0;
         max_mag     <= '0;
         max_bin     <= '0;
         have_max    <= 1'b0;
      end else begin
         if (p_valid) begin
            max_mag  <= nxt_mag;
            max_bin  <= nxt_bin;
            have_max <= have_max | eligible;
         end

         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  if (frame_end) begin
                     bin_cnt  <= '0;
                     err_q    <= err_now;
                     s_tready <= 1'b0;
                     state    <= ST_FLUSH;
                  end else begin
                     bin_cnt  <= bin_cnt + BIN_W'(1);
                  end
               end
            end

            ST_FLUSH: begin
               if (p_valid && p_last) begin
                  m_bin       <= nxt_bin;
                  m_mag       <= nxt_mag;
                  m_detect    <= (nxt_mag > threshold);
                  m_frame_err <= err_q;
                  m_valid     <= 1'b1;
                  state       <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (m_ready) begin
                  m_valid  <= 1'b0;
                  s_tready <= 1'b1;
                  max_mag  <= '0;
                  max_bin  <= '0;
                  have_max <= 1'b0;
                  err_q    <= 1'b0;
                  state    <= ST_ACCUM;
               end
            end

            default: begin
               state    <= ST_ACCUM;
               s_tready <= 1'b1;
               m_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_range_peak_detector.sv
// -----------------------------------------------------------------------------
// tb_range_peak_detector
// Scoreboard bench: a reference model computes each frame's expected result
// as it is driven and queues it; results are popped and compared when the
// DUT raises m_valid.
// -----------------------------------------------------------------------------
module tb_range_peak_detector;

   localparam int unsigned FL   = 128;
   localparam int unsigned DW   = 16;
   localparam int unsigned SKIP = 1;
   localparam int unsigned NONE = 9999;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_tvalid;
   logic          s_tready;
   logic [31:0]   s_tdata;
   logic          s_tlast;
   logic [32:0]   threshold;
   logic          m_valid;
   logic          m_ready;
   logic [6:0]    m_bin;
   logic [32:0]   m_mag;
   logic          m_detect;
   logic          m_frame_err;

   range_peak_detector #(
      .FRAME_LENGTH (FL),
      .DATA_W       (DW),
      .SKIP_BINS    (SKIP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdata     (s_tdata),
      .s_tlast     (s_tlast),
      .threshold   (threshold),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_bin       (m_bin),
      .m_mag       (m_mag),
      .m_detect    (m_detect),
      .m_frame_err (m_frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned bin;
      longint      mag;
      bit          det;
      bit          err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc_end = 0;
   int   re_a[FL];
   int   im_a[FL];

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_const(input int r, input int i);
      for (int unsigned k = 0; k < FL; k++) begin
         re_a[k] = r;
         im_a[k] = i;
      end
   endtask

   task automatic fill_rand();
      for (int unsigned k = 0; k < FL; k++) begin
         re_a[k] = int'($urandom_range(0, 65535)) - 32768;
         im_a[k] = int'($urandom_range(0, 65535)) - 32768;
      end
   endtask

   task automatic drive_beat(input int r, input int i, input bit last);
      int unsigned guard = 0;
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = {16'(i), 16'(r)};
      s_tlast  = last;
      while (!s_tready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check_val("tready_timeout", 0, 1);
      cyc_end = cyc;
   endtask

   // Drives n_beats from re_a/im_a with tlast on tlast_idx (NONE for no tlast);
   // when push is set, queues the model's expected result for the frame.
   task automatic send_frame(input int unsigned n_beats, input int unsigned tlast_idx,
                             input longint thr, input bit push);
      exp_t   e;
      longint mag;
      bit     have = 1'b0;
      bit     last;
      threshold = 33'(thr);
      e.bin = 0;
      e.mag = 0;
      e.err = 1'b0;
      for (int unsigned k = 0; k < n_beats; k++) begin
         last = (k == tlast_idx);
         if (k >= SKIP) begin
            mag = longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k];
            if (!have || mag > e.mag) begin
               e.mag = mag;
               e.bin = k;
            end
            have = 1'b1;
         end
         if (last || k == FL - 1) e.err = (last != (k == FL - 1));
      end
      e.det = (e.mag > thr);
      if (push) sb.push_back(e);
      for (int unsigned k = 0; k < n_beats; k++)
         drive_beat(re_a[k], im_a[k], k == tlast_idx);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic check_result(input string name, input bit chk_lat, input int unsigned hold);
      exp_t        e;
      int unsigned k = 0;
      check_val({name, "_sb_depth"}, sb.size(), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      while (!m_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_val({name, "_valid"}, m_valid, 1);
      if (chk_lat) check_val({name, "_latency"}, cyc - cyc_end, 3);
      check_val({name, "_bin"}, m_bin, e.bin);
      check_val({name, "_mag"}, m_mag, e.mag);
      check_val({name, "_detect"}, m_detect, e.det);
      check_val({name, "_frame_err"}, m_frame_err, e.err);
      for (int unsigned h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val({name, "_hold_valid"}, m_valid, 1);
         check_val({name, "_hold_tready"}, s_tready, 0);
         check_val({name, "_hold_bin"}, m_bin, e.bin);
         check_val({name, "_hold_mag"}, m_mag, e.mag);
         check_val({name, "_hold_detect"}, m_detect, e.det);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check_val({name, "_post_valid"}, m_valid, 0);
      check_val({name, "_post_tready"}, s_tready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      s_tlast   = 1'b0;
      threshold = '0;
      m_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_tready", s_tready, 1);
      check_val("rst_valid", m_valid, 0);
      check_val("rst_bin", m_bin, 0);
      check_val("rst_mag", m_mag, 0);
      check_val("rst_detect", m_detect, 0);
      check_val("rst_frame_err", m_frame_err, 0);
      rst = 1'b0;

      // Single strong bin, latency check
      fill_const(1, 1);
      re_a[37] = 300;
      im_a[37] = -400;
      send_frame(128, 127, 0, 1'b1);
      check_result("peak37", 1'b1, 0);

      // Large DC bin skipped
      fill_const(0, 0);
      re_a[0] = 10000;
      re_a[5] = 100;
      send_frame(128, 127, 0, 1'b1);
      check_result("skip_dc", 1'b1, 0);

      // Tie at full scale keeps lowest index; threshold equal -> no detect
      fill_const(0, 0);
      re_a[20] = -32768;
      im_a[20] = -32768;
      re_a[90] = -32768;
      im_a[90] = -32768;
      send_frame(128, 127, 64'd2147483648, 1'b1);
      check_result("tie_full", 1'b0, 0);

      // Early tlast, then missing tlast (forced end)
      fill_rand();
      send_frame(64, 63, 64'd1000000, 1'b1);
      check_result("early_tlast", 1'b1, 0);
      fill_rand();
      send_frame(128, NONE, 64'd1000000, 1'b1);
      check_result("no_tlast", 1'b1, 0);

      // Frame of only a skipped bin: empty result
      fill_const(500, 500);
      send_frame(1, 0, 0, 1'b1);
      check_result("empty", 1'b1, 0);

      // Backpressure and threshold boundary
      fill_const(1, 1);
      re_a[37] = 300;
      im_a[37] = -400;
      send_frame(128, 127, 64'd250000, 1'b1);
      check_result("hold_thr_eq", 1'b0, 20);
      send_frame(128, 127, 64'd249999, 1'b1);
      check_result("thr_below", 1'b0, 0);

      // Reset mid-frame discards partial frame
      fill_rand();
      send_frame(60, NONE, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int unsigned k = 0; k < 10; k++) begin
         @(negedge clk);
         check_val("rst_mid_valid", m_valid, 0);
      end
      check_val("rst_mid_tready", s_tready, 1);
      fill_rand();
      send_frame(128, 127, 64'd500000000, 1'b1);
      check_result("after_rst", 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
